// File: rtl/event_counter_pkg.sv
// Shared types and helpers for the event counter bank.
package event_counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Select width for a channel index; a single channel still needs one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One event counter channel: count, threshold, wrap/saturate mode and sticky overflow.
module counter_channel
  import event_counter_pkg::*;
#(
  parameter int unsigned               COUNTER_BITS = 32,
  parameter logic [COUNTER_BITS-1:0]   THR_RESET    = '1,
  parameter bit                        SAT_RESET    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    inc_i,
  input  logic                    clr_i,
  input  logic                    cfg_we_i,
  input  logic [COUNTER_BITS-1:0] cfg_thr_i,
  input  logic                    cfg_sat_i,
  output logic [COUNTER_BITS-1:0] count_o,
  output logic                    trigger_o,
  output logic                    ovf_o
);

  localparam logic [COUNTER_BITS-1:0] CntMax = '1;

  logic [COUNTER_BITS-1:0] count_q, count_d;
  logic [COUNTER_BITS-1:0] thr_q, thr_d;
  cnt_mode_e               mode_q, mode_d;
  logic                    ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (inc_i) begin
      if (count_q == CntMax) begin
        ovf_d   = 1'b1;
        count_d = (mode_q == CNT_SAT) ? CntMax : '0;
      end else begin
        count_d = count_q + COUNTER_BITS'(1);
      end
    end
  end

  // Config only touches threshold and mode, so it composes freely with counting.
  always_comb begin
    thr_d  = thr_q;
    mode_d = mode_q;
    if (cfg_we_i) begin
      thr_d  = cfg_thr_i;
      mode_d = cfg_sat_i ? CNT_SAT : CNT_WRAP;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
      thr_q   <= THR_RESET;
      mode_q  <= SAT_RESET ? CNT_SAT : CNT_WRAP;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      thr_q   <= thr_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o   = count_q;
  assign trigger_o = (count_q >= thr_q);
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent event counters with config decode and a registered readback mux.
module event_counter_bank
  import event_counter_pkg::*;
#(
  parameter int unsigned             COUNTER_BITS = 32,
  parameter int unsigned             N_CHANNELS   = 4,
  parameter logic [COUNTER_BITS-1:0] THR_RESET    = '1,
  parameter bit                      SAT_RESET    = 1'b0,
  localparam int unsigned            CH_W         = ch_w(N_CHANNELS)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_CHANNELS-1:0]   en_i,
  input  logic [N_CHANNELS-1:0]   event_i,
  input  logic [N_CHANNELS-1:0]   clr_i,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_sel_i,
  input  logic [COUNTER_BITS-1:0] cfg_thr_i,
  input  logic                    cfg_sat_i,
  input  logic [CH_W-1:0]         rd_sel_i,
  output logic [COUNTER_BITS-1:0] rd_count_o,
  output logic [N_CHANNELS-1:0]   trigger_o,
  output logic [N_CHANNELS-1:0]   ovf_o
);

  logic [N_CHANNELS-1:0][COUNTER_BITS-1:0] counts;
  logic [N_CHANNELS-1:0]                   ch_we;
  logic [COUNTER_BITS-1:0]                 rd_count_q, rd_count_d;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : gen_ch
    // Out-of-range selects match no channel, so such writes are dropped.
    assign ch_we[g] = cfg_we_i && (cfg_sel_i == CH_W'(g));

    counter_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .THR_RESET    (THR_RESET),
      .SAT_RESET    (SAT_RESET)
    ) u_channel (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .inc_i     (en_i[g] & event_i[g]),
      .clr_i     (clr_i[g]),
      .cfg_we_i  (ch_we[g]),
      .cfg_thr_i (cfg_thr_i),
      .cfg_sat_i (cfg_sat_i),
      .count_o   (counts[g]),
      .trigger_o (trigger_o[g]),
      .ovf_o     (ovf_o[g])
    );
  end

  always_comb begin
    rd_count_d = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      if (rd_sel_i == CH_W'(i)) rd_count_d = counts[i];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rd_count_q <= '0;
    else         rd_count_q <= rd_count_d;
  end

  assign rd_count_o = rd_count_q;

endmodule
